// File: rtl/pixel_stream_writer.sv
// ---------------------------------------------------------------------------
// pixel_stream_writer
//
// Turns a byte stream of pixel packets into single-cycle RGB565 write strobes
// for the LED panel driver's video memory port.
//
// Packet layout:
//   byte0 = start address [15:8], byte1 = start address [7:0],
//   then two bytes per pixel, low byte first (wdat = {hi, lo}).
// The first pixel goes to the start address. Each later pixel goes to the
// next address up. Addresses are bounds-checked against PIXEL_COUNT.
// Malformed packets are discarded and counted.
//
// Optional feature macro: PSW_STATS_EN
//   defined   -> pkt_count / err_count are live wrapping counters
//   undefined -> both outputs are tied to zero and no counter logic exists
//
// Parameters:
//   PIXEL_COUNT  number of addressable pixels (valid addresses 0..PIXEL_COUNT-1)
//   STAT_W       width of the statistics counters
//
// Ports:
//   ctrl_clk     sole clock, rising edge
//   ctrl_resetn  synchronous active-low reset
//   in_valid     in_data carries a byte this cycle (no backpressure)
//   in_data      stream byte
//   in_sof       first byte of a packet (qualified by in_valid)
//   in_eof       last byte of a packet (qualified by in_valid)
//   ctrl_en      one-cycle write strobe to the panel driver
//   ctrl_addr    pixel address, valid with ctrl_en, held otherwise
//   ctrl_wdat    RGB565 pixel, valid with ctrl_en, held otherwise
//   busy         high while the parser is inside a packet (not IDLE)
//   frame_done   one-cycle pulse when a packet ends cleanly
//   pkt_count    clean packet count (wraps)
//   err_count    malformed packet count (wraps)
// ---------------------------------------------------------------------------
module pixel_stream_writer #(
  parameter int PIXEL_COUNT = 2048,
  parameter int STAT_W      = 16
) (
  input  logic              ctrl_clk,
  input  logic              ctrl_resetn,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_sof,
  input  logic              in_eof,
  output logic              ctrl_en,
  output logic [15:0]       ctrl_addr,
  output logic [15:0]       ctrl_wdat,
  output logic              busy,
  output logic              frame_done,
  output logic [STAT_W-1:0] pkt_count,
  output logic [STAT_W-1:0] err_count
);

  // Addresses are compared in 17 bits so that a PIXEL_COUNT of 65536 still
  // works for the range check and the end-of-memory check.
  localparam logic [16:0] LP_PIXEL_COUNT = 17'(PIXEL_COUNT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_LO,
    ST_PIX_LO,
    ST_PIX_HI,
    ST_DROP
  } state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic [15:0] r_addr;
  logic [7:0]  r_pixLo;

  logic        r_ctrlEn;
  logic [15:0] r_ctrlAddr;
  logic [15:0] r_ctrlWdat;
  logic        r_busy;
  logic        r_frameDone;

  logic [16:0] w_hdrAddr;
  logic        w_hdrInRange;
  logic [16:0] w_addrNext;
  logic        w_lastPixel;
  logic        w_doWrite;
  logic        w_cleanEnd;

  // The full header address is formed from the latched high byte and the byte
  // arriving in ADDR_LO, so the range check happens on that same byte.
  assign w_hdrAddr    = {1'b0, r_addr[15:8], in_data};
  assign w_hdrInRange = (w_hdrAddr < LP_PIXEL_COUNT);

  // The pixel being written in PIX_HI sits at r_addr. If the address after it
  // falls off the end of memory, any further byte in the packet is an overrun.
  assign w_addrNext   = {1'b0, r_addr} + 17'd1;
  assign w_lastPixel  = (w_addrNext == LP_PIXEL_COUNT);

  // Next-state and strobe decode. An in_sof byte always restarts parsing. It
  // becomes byte0 of a new packet, or closes the packet immediately when it
  // also carries in_eof. Bytes with in_valid low change nothing.
  always_comb begin
    w_nextState = r_state;
    w_doWrite   = 1'b0;
    w_cleanEnd  = 1'b0;
    if (in_valid) begin
      if (in_sof) begin
        w_nextState = in_eof ? ST_IDLE : ST_ADDR_LO;
      end else begin
        case (r_state)
          ST_IDLE: begin
            w_nextState = ST_IDLE;
          end
          ST_ADDR_LO: begin
            if (in_eof) begin
              w_nextState = ST_IDLE;
            end else if (!w_hdrInRange) begin
              w_nextState = ST_DROP;
            end else begin
              w_nextState = ST_PIX_LO;
            end
          end
          ST_PIX_LO: begin
            w_nextState = in_eof ? ST_IDLE : ST_PIX_HI;
          end
          ST_PIX_HI: begin
            w_doWrite = 1'b1;
            if (in_eof) begin
              w_nextState = ST_IDLE;
              w_cleanEnd  = 1'b1;
            end else if (w_lastPixel) begin
              w_nextState = ST_DROP;
            end else begin
              w_nextState = ST_PIX_LO;
            end
          end
          ST_DROP: begin
            w_nextState = in_eof ? ST_IDLE : ST_DROP;
          end
          default: begin
            w_nextState = ST_IDLE;
          end
        endcase
      end
    end
  end

  // State register, datapath latches and all registered outputs. busy is
  // registered from the next state, so it matches the state it describes.
  // A reset on the edge that would launch a write suppresses that write,
  // because ctrl_en is cleared in the reset branch.
  always_ff @(posedge ctrl_clk) begin
    if (!ctrl_resetn) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_pixLo     <= '0;
      r_ctrlEn    <= 1'b0;
      r_ctrlAddr  <= '0;
      r_ctrlWdat  <= '0;
      r_busy      <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_busy      <= (w_nextState != ST_IDLE);
      r_ctrlEn    <= w_doWrite;
      r_frameDone <= w_cleanEnd;
      if (in_valid) begin
        if (in_sof) begin
          r_addr[15:8] <= in_data;
        end else begin
          case (r_state)
            ST_ADDR_LO: begin
              r_addr[7:0] <= in_data;
            end
            ST_PIX_LO: begin
              r_pixLo <= in_data;
            end
            ST_PIX_HI: begin
              r_ctrlAddr <= r_addr;
              r_ctrlWdat <= {in_data, r_pixLo};
              r_addr     <= r_addr + 16'd1;
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  assign ctrl_en    = r_ctrlEn;
  assign ctrl_addr  = r_ctrlAddr;
  assign ctrl_wdat  = r_ctrlWdat;
  assign busy       = r_busy;
  assign frame_done = r_frameDone;

`ifdef PSW_STATS_EN
  logic [1:0]        w_errInc;
  logic [STAT_W-1:0] r_pktCount;
  logic [STAT_W-1:0] r_errCount;

  // Error decode. Each malformed packet is counted once, at the byte that
  // proves it bad. An in_sof byte can add two errors: one for aborting a live
  // packet (skipped in DROP, which was already counted) and one when the new
  // packet is itself a one-byte packet.
  always_comb begin
    w_errInc = 2'd0;
    if (in_valid) begin
      if (in_sof) begin
        if ((r_state != ST_IDLE) && (r_state != ST_DROP)) begin
          w_errInc = w_errInc + 2'd1;
        end
        if (in_eof) begin
          w_errInc = w_errInc + 2'd1;
        end
      end else begin
        case (r_state)
          ST_ADDR_LO: begin
            if (in_eof || !w_hdrInRange) begin
              w_errInc = 2'd1;
            end
          end
          ST_PIX_LO: begin
            if (in_eof) begin
              w_errInc = 2'd1;
            end
          end
          ST_PIX_HI: begin
            if (!in_eof && w_lastPixel) begin
              w_errInc = 2'd1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Statistics counters. They wrap silently, and a clean end lands in the
  // same cycle as the final write strobe and frame_done.
  always_ff @(posedge ctrl_clk) begin
    if (!ctrl_resetn) begin
      r_pktCount <= '0;
      r_errCount <= '0;
    end else begin
      r_pktCount <= r_pktCount + STAT_W'(w_cleanEnd);
      r_errCount <= r_errCount + STAT_W'(w_errInc);
    end
  end

  assign pkt_count = r_pktCount;
  assign err_count = r_errCount;
`else
  assign pkt_count = '0;
  assign err_count = '0;
`endif

endmodule

// File: doc/pixel_stream_writer.md
# pixel_stream_writer

Converts a byte stream of pixel packets (from the network/SPI receive path) into single-cycle RGB565 write strobes for the LED panel driver's video memory. Each packet carries a 16-bit start pixel address followed by pixel words. The block assembles 16-bit pixels, auto-increments the write address and bounds-checks it. It discards malformed packets and reports packet and error statistics. It sits directly upstream of the panel driver and drives that driver's `ctrl_en`/`ctrl_addr`/`ctrl_wdat` write port.

## Interface
- `PIXEL_COUNT`, 2048: number of addressable pixels (64×32); valid addresses are 0..PIXEL_COUNT-1.
- `STAT_W`, 16: width of the statistics counters.

Ports:
- `ctrl_clk`  in  1  sole clock; all logic is on its rising edge.
- `ctrl_resetn`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  `in_data` byte is valid this cycle; one byte per cycle max; there is no backpressure.
- `in_data`  in  8  stream byte.
- `in_sof`  in  1  qualifies the first byte of a packet (sampled only with `in_valid`).
- `in_eof`  in  1  qualifies the last byte of a packet (sampled only with `in_valid`).
- `ctrl_en`  out  1  one-cycle write strobe.
- `ctrl_addr`  out  16  pixel address, valid with `ctrl_en`.
- `ctrl_wdat`  out  16  RGB565 pixel, valid with `ctrl_en`.
- `busy`  out  1  high while in any state other than IDLE.
- `frame_done`  out  1  one-cycle pulse after a packet ends cleanly.
- `pkt_count`  out  STAT_W  count of clean packets, wraps modulo 2^STAT_W.
- `err_count`  out  STAT_W  count of malformed packets, wraps modulo 2^STAT_W.

## Operation
- Packet format:
  - byte0 = addr[15:8], byte1 = addr[7:0].
  - Then 2 bytes per pixel, low byte first: wdat = {hi, lo}.
  - First pixel is written to addr; each following pixel is written to addr+1, addr+2, and so on.
- States: IDLE, ADDR_LO, PIX_LO, PIX_HI, DROP.
- IDLE:
  - A valid byte with `in_sof` latches addr[15:8] → ADDR_LO.
  - Valid bytes without `in_sof` are ignored; no error is counted.
- ADDR_LO:
  - A valid byte latches addr[7:0].
  - If the full addr ≥ PIXEL_COUNT → DROP; otherwise → PIX_LO.
- PIX_LO: a valid byte is latched as the low byte → PIX_HI.
- PIX_HI: a valid byte forms the pixel and the write is issued next cycle.
  - The address then increments. If the incremented address equals PIXEL_COUNT and more bytes follow → DROP.
  - Otherwise → PIX_LO.
- DROP: consumes bytes until `in_eof`, then goes to IDLE; the error was already counted on entry.
- Clean end: `in_eof` on a PIX_HI byte (pixel written) → IDLE, `pkt_count`+1, `frame_done` pulse.
- Error cases (`err_count`+1 each, no further writes for that packet):
  - `in_eof` in IDLE together with `in_sof`, i.e. a 1-byte packet.
  - `in_eof` in ADDR_LO: header only, no pixels.
  - `in_eof` in PIX_LO: odd trailing byte, which is dropped.
  - Address out of range at header.
  - Overrun past PIXEL_COUNT-1.
- `in_sof` outside IDLE:
  - Aborts the current packet; any partial pixel is discarded.
  - Counts one error, unless the state is DROP, where the error is already counted.
  - The byte is taken as the new byte0 → ADDR_LO.
- Pixel data is not inspected or converted; gamma correction stays in the panel driver.
- Counter width: `STAT_W`; both counters wrap silently.

## Timing
- Reset values: `ctrl_en`=0, `ctrl_addr`=0, `ctrl_wdat`=0, `busy`=0, `frame_done`=0, `pkt_count`=0, `err_count`=0; state=IDLE.
- All outputs are registered.
- `ctrl_en` goes high in the cycle after the PIX_HI byte is sampled; `ctrl_addr`/`ctrl_wdat` hold their last value when `ctrl_en`=0.
- Maximum write rate is one pixel per 2 cycles, so there are never back-to-back `ctrl_en` pulses.
- `frame_done` and the counter update occur in the same cycle as the final `ctrl_en`.
- Counters update 1 cycle after the byte that terminates or aborts the packet.
- `in_valid`=0 cycles stall the FSM with no effect; gaps of any length inside a packet are legal.
- Reset asserted mid-packet: the FSM returns to IDLE on that edge and any pending write is suppressed. A packet continuing after reset is ignored until the next `in_sof`.

## Configuration
- `PSW_STATS_EN`:
  - Defined: `pkt_count`/`err_count` are implemented as above.
  - Undefined: both outputs are tied to 0 and the counter logic is not synthesized.
  - All other behaviour is identical with or without the macro, including `frame_done` and packet dropping.

## Test plan
- Bytes 00 05 34 12 78 56 with sof/eof → writes (5,0x1234) then (6,0x5678); `frame_done` pulses once; `pkt_count`=1.
- Header 07 FF, then 4 pixels, eof → only (2047,px0) is written; `err_count`=1; state returns to IDLE after eof.
- Header 08 00 (addr 2048), then 2 pixels → no `ctrl_en`; `err_count`=1.
- Packet 00 00 AA BB CC with eof on CC → one write (0,0xBBAA); `err_count`=1; `pkt_count`=0.
- Mid-packet `in_sof` with byte 00 followed by 10 11 22 eof → the partial pixel is dropped, `err_count`=1, then write (0x0010,0x2211) and `pkt_count`=1.
- `ctrl_resetn` low between PIX_LO and PIX_HI, then the remaining bytes without sof → no write; all outputs 0; `busy`=0.
